// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Priority interrupt controller between peripheral interrupt lines and the CPU
// control unit. Rising edges on irq_in are latched into a pending register,
// filtered by a writable enable mask, and the highest-priority candidate
// (lowest index) is offered to the CPU together with its handler address from
// a writable vector table.
//
// Build option:
//   INTC_NESTING_EN  defined   -> a candidate that outranks every in-service
//                                 source preempts it (nested handlers).
//                    undefined -> single-level: no request while anything is in
//                                 service, and reti clears all of active.
//
// Ports:
//   clk        system clock, all state updates on the rising edge
//   reset      synchronous active-high reset
//   irq_in     raw interrupt lines (bit 0 = highest priority)
//   calli      CPU accepts the current request this cycle
//   reti       CPU executes return-from-interrupt
//   mask_we    mask register write enable, mask_data = new mask (1 = enabled)
//   vec_we     vector table write enable, vec_idx/vec_data = entry and address
//   int_req    request to the CPU
//   vec_addr   handler address of the selected source
//   sel_idx    index of the selected source (0 when nothing is a candidate)
//   pending    pending register
//   active     in-service register
//   in_service OR-reduction of active
// -----------------------------------------------------------------------------
module interrupt_controller #(
  parameter int                N_IRQ      = 8,
  parameter int                ADDR_W     = 10,
  parameter int                IDX_W      = 3,
  parameter logic [ADDR_W-1:0] VEC_BASE   = 10'b1000000000,
  parameter int                VEC_STRIDE = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IRQ-1:0]  irq_in,
  input  logic              calli,
  input  logic              reti,
  input  logic              mask_we,
  input  logic [N_IRQ-1:0]  mask_data,
  input  logic              vec_we,
  input  logic [IDX_W-1:0]  vec_idx,
  input  logic [ADDR_W-1:0] vec_data,
  output logic              int_req,
  output logic [ADDR_W-1:0] vec_addr,
  output logic [IDX_W-1:0]  sel_idx,
  output logic [N_IRQ-1:0]  pending,
  output logic [N_IRQ-1:0]  active,
  output logic              in_service
);

  // Priority level needs one extra code (N_IRQ) meaning "nothing in service".
  localparam int LVL_W = IDX_W + 1;

  logic [N_IRQ-1:0]  irq_prev_q, irq_prev_d;
  logic [N_IRQ-1:0]  pending_q, pending_d;
  logic [N_IRQ-1:0]  active_q, active_d;
  logic [N_IRQ-1:0]  mask_q, mask_d;
  logic [ADDR_W-1:0] vec_tab_q [N_IRQ];
  logic [ADDR_W-1:0] vec_tab_d [N_IRQ];

  logic [N_IRQ-1:0]  set_mask;
  logic [N_IRQ-1:0]  cand;
  logic [N_IRQ-1:0]  clr_onehot;
  logic [N_IRQ-1:0]  active_after_reti;
  logic [IDX_W-1:0]  sel_idx_c;
  logic [LVL_W-1:0]  cur_level;
  logic [ADDR_W-1:0] vec_addr_c;
  logic              int_req_c;
  logic              accept;

  // Selection: lowest set index of candidates and of the in-service set.
  // Scanning downwards lets the last hit (the lowest index) win.
  always_comb begin
    set_mask  = irq_in & ~irq_prev_q;
    cand      = pending_q & mask_q;
    sel_idx_c = '0;
    cur_level = LVL_W'(N_IRQ);
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (cand[i])     sel_idx_c = IDX_W'(i);
      if (active_q[i]) cur_level = LVL_W'(i);
    end
  end

  // Request generation. With nothing in service cur_level is N_IRQ, so any
  // candidate qualifies; the single-level build additionally blocks while busy.
  always_comb begin
`ifdef INTC_NESTING_EN
    int_req_c = (cand != '0) && ({1'b0, sel_idx_c} < cur_level);
`else
    int_req_c = (cand != '0) && ({1'b0, sel_idx_c} < cur_level) && (active_q == '0);
`endif
  end

  assign accept = calli && int_req_c;

  // One-hot of the accepted source, and vector lookup as a compare-mux so the
  // index never has to be range-checked against the table size.
  always_comb begin
    clr_onehot = '0;
    vec_addr_c = vec_tab_q[0];
    for (int i = 0; i < N_IRQ; i++) begin
      clr_onehot[i] = accept && (sel_idx_c == IDX_W'(i));
      if (sel_idx_c == IDX_W'(i)) vec_addr_c = vec_tab_q[i];
    end
  end

  // reti is applied to the old active value before the calli set. With
  // nesting, x & (x-1) drops only the lowest set bit (innermost handler) and
  // leaves an empty set empty.
  always_comb begin
`ifdef INTC_NESTING_EN
    active_after_reti = reti ? (active_q & (active_q - N_IRQ'(1))) : active_q;
`else
    active_after_reti = reti ? '0 : active_q;
`endif
    active_d   = active_after_reti | clr_onehot;
    // A fresh edge on the bit being accepted wins and keeps it pending.
    pending_d  = (pending_q & ~clr_onehot) | set_mask;
    irq_prev_d = irq_in;
    mask_d     = mask_we ? mask_data : mask_q;
    // Only entries 0..N_IRQ-1 can match, so out-of-range writes fall away.
    for (int i = 0; i < N_IRQ; i++) begin
      vec_tab_d[i] = (vec_we && (vec_idx == IDX_W'(i))) ? vec_data : vec_tab_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // Tracking irq_in during reset means a line already high when reset is
      // released is not seen as an edge; it has to fall and rise again.
      irq_prev_q <= irq_in;
      pending_q  <= '0;
      active_q   <= '0;
      mask_q     <= '1;
      for (int i = 0; i < N_IRQ; i++) begin
        vec_tab_q[i] <= ADDR_W'(VEC_BASE + i * VEC_STRIDE);
      end
    end else begin
      irq_prev_q <= irq_prev_d;
      pending_q  <= pending_d;
      active_q   <= active_d;
      mask_q     <= mask_d;
      for (int i = 0; i < N_IRQ; i++) begin
        vec_tab_q[i] <= vec_tab_d[i];
      end
    end
  end

  assign int_req    = int_req_c;
  assign vec_addr   = vec_addr_c;
  assign sel_idx    = sel_idx_c;
  assign pending    = pending_q;
  assign active     = active_q;
  assign in_service = |active_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
//
// Table-driven bench: each record holds the inputs applied for one clock cycle
// and the outputs expected after that edge. Records are pushed to a scoreboard
// queue when driven and popped/compared one time unit after the clock edge.
// The DUT is built with IDX_W=4 so that an out-of-range vector index (9) can
// be driven. Expectations follow the nesting option of the build.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

`ifdef INTC_NESTING_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif

  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] irq;
    logic       calli;
    logic       reti;
    logic       mask_we;
    logic [7:0] mask_data;
    logic       vec_we;
    logic [3:0] vec_idx;
    logic [9:0] vec_data;
    logic       exp_req;
    logic [3:0] exp_sel;
    logic [9:0] exp_vec;
    logic [7:0] exp_pend;
    logic [7:0] exp_act;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] irq_in;
  logic       calli, reti, mask_we, vec_we;
  logic [7:0] mask_data;
  logic [3:0] vec_idx;
  logic [9:0] vec_data;
  logic       int_req, in_service;
  logic [9:0] vec_addr;
  logic [3:0] sel_idx;
  logic [7:0] pending, active;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[$];
  vec_t sb[$];

  interrupt_controller #(
    .N_IRQ(8), .ADDR_W(10), .IDX_W(4), .VEC_BASE(10'b1000000000), .VEC_STRIDE(16)
  ) dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .calli(calli), .reti(reti),
    .mask_we(mask_we), .mask_data(mask_data), .vec_we(vec_we), .vec_idx(vec_idx),
    .vec_data(vec_data), .int_req(int_req), .vec_addr(vec_addr), .sel_idx(sel_idx),
    .pending(pending), .active(active), .in_service(in_service)
  );

  always #5 clk = ~clk;

  task automatic add(input string n, input logic rst, input logic [7:0] irq,
                     input logic ca, input logic re,
                     input logic req, input logic [3:0] sel, input logic [9:0] va,
                     input logic [7:0] pe, input logic [7:0] ac,
                     input logic mwe = 1'b0, input logic [7:0] md = 8'h00,
                     input logic vwe = 1'b0, input logic [3:0] vi = 4'd0,
                     input logic [9:0] vd = 10'h000);
    vec_t v;
    v.name = n; v.rst = rst; v.irq = irq; v.calli = ca; v.reti = re;
    v.mask_we = mwe; v.mask_data = md; v.vec_we = vwe; v.vec_idx = vi; v.vec_data = vd;
    v.exp_req = req; v.exp_sel = sel; v.exp_vec = va; v.exp_pend = pe; v.exp_act = ac;
    vecs.push_back(v);
  endtask

  task automatic check_front();
    vec_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_empty: got 0 entries, expected at least 1");
      return;
    end
    e = sb.pop_front();
    n_checks++;
    if ({int_req, sel_idx, vec_addr, pending, active, in_service} !==
        {e.exp_req, e.exp_sel, e.exp_vec, e.exp_pend, e.exp_act, |e.exp_act}) begin
      n_fail++;
      $display("FAIL %s: got req=%0d sel=%0d vec=%h pend=%h act=%h insvc=%0d, expected req=%0d sel=%0d vec=%h pend=%h act=%h insvc=%0d",
               e.name, int_req, sel_idx, vec_addr, pending, active, in_service,
               e.exp_req, e.exp_sel, e.exp_vec, e.exp_pend, e.exp_act, |e.exp_act);
    end else begin
      $display("ok   %s: req=%0d sel=%0d vec=%h pend=%h act=%h",
               e.name, int_req, sel_idx, vec_addr, pending, active);
    end
  endtask

  task automatic apply(input vec_t v);
    @(negedge clk);
    reset = v.rst; irq_in = v.irq; calli = v.calli; reti = v.reti;
    mask_we = v.mask_we; mask_data = v.mask_data;
    vec_we = v.vec_we; vec_idx = v.vec_idx; vec_data = v.vec_data;
    sb.push_back(v);
    @(posedge clk);
    #1;
    check_front();
  endtask

  initial begin
    reset = 1'b1; irq_in = '0; calli = 1'b0; reti = 1'b0;
    mask_we = 1'b0; mask_data = '0; vec_we = 1'b0; vec_idx = '0; vec_data = '0;

    //   name           rst irq    ca re  req   sel   vec       pend    act
    add("reset",        1, 8'h00, 0, 0, 1'b0, 4'd0, 10'h200, 8'h00, 8'h00);
    add("reset_hold",   1, 8'h00, 0, 0, 1'b0, 4'd0, 10'h200, 8'h00, 8'h00);
    add("irq2_rise",    0, 8'h04, 0, 0, 1'b1, 4'd2, 10'h220, 8'h04, 8'h00);
    add("irq2_low",     0, 8'h00, 0, 0, 1'b1, 4'd2, 10'h220, 8'h04, 8'h00);
    add("calli2",       0, 8'h00, 1, 0, 1'b0, 4'd0, 10'h200, 8'h00, 8'h04);
    add("irq5_lower",   0, 8'h20, 0, 0, 1'b0, 4'd5, 10'h250, 8'h20, 8'h04);
    add("irq0_higher",  0, 8'h01, 0, 0, NEST, 4'd0, 10'h200, 8'h21, 8'h04);
    add("calli0_nest",  0, 8'h00, 1, 0, 1'b0, NEST ? 4'd5 : 4'd0,
        NEST ? 10'h250 : 10'h200, NEST ? 8'h20 : 8'h21, NEST ? 8'h05 : 8'h04);
    add("reti_inner",   0, 8'h00, 0, 1, !NEST, NEST ? 4'd5 : 4'd0,
        NEST ? 10'h250 : 10'h200, NEST ? 8'h20 : 8'h21, NEST ? 8'h04 : 8'h00);
    add("reti_outer",   0, 8'h00, 0, 1, 1'b1, NEST ? 4'd5 : 4'd0,
        NEST ? 10'h250 : 10'h200, NEST ? 8'h20 : 8'h21, 8'h00);
    add("reset_b",      1, 8'h00, 0, 0, 1'b0, 4'd0, 10'h200, 8'h00, 8'h00);
    add("mask_fe_wr",   0, 8'h00, 0, 0, 1'b0, 4'd0, 10'h200, 8'h00, 8'h00, 1'b1, 8'hFE);
    add("irq0_masked",  0, 8'h01, 0, 0, 1'b0, 4'd0, 10'h200, 8'h01, 8'h00);
    add("mask_ff_wr",   0, 8'h00, 0, 0, 1'b1, 4'd0, 10'h200, 8'h01, 8'h00, 1'b1, 8'hFF);
    add("calli0_unmask",0, 8'h00, 1, 0, 1'b0, 4'd0, 10'h200, 8'h00, 8'h01);
    add("reti0",        0, 8'h00, 0, 1, 1'b0, 4'd0, 10'h200, 8'h00, 8'h00);
    add("vec3_wr",      0, 8'h00, 0, 0, 1'b0, 4'd0, 10'h200, 8'h00, 8'h00,
        1'b0, 8'h00, 1'b1, 4'd3, 10'h3F0);
    add("vec9_wr",      0, 8'h00, 0, 0, 1'b0, 4'd0, 10'h200, 8'h00, 8'h00,
        1'b0, 8'h00, 1'b1, 4'd9, 10'h155);
    add("irq3_newvec",  0, 8'h08, 0, 0, 1'b1, 4'd3, 10'h3F0, 8'h08, 8'h00);
    add("calli3",       0, 8'h00, 1, 0, 1'b0, 4'd0, 10'h200, 8'h00, 8'h08);
    add("reti3",        0, 8'h00, 0, 1, 1'b0, 4'd0, 10'h200, 8'h00, 8'h00);
    add("irq1_rise",    0, 8'h02, 0, 0, 1'b1, 4'd1, 10'h210, 8'h02, 8'h00);
    add("irq1_low",     0, 8'h00, 0, 0, 1'b1, 4'd1, 10'h210, 8'h02, 8'h00);
    add("calli1_edge",  0, 8'h02, 1, 0, 1'b0, 4'd1, 10'h210, 8'h02, 8'h02);
    for (int k = 0; k < 10; k++)
      add("irq1_hold",  0, 8'h02, 0, 0, 1'b0, 4'd1, 10'h210, 8'h02, 8'h02);
    add("irq1_fall",    0, 8'h00, 0, 0, 1'b0, 4'd1, 10'h210, 8'h02, 8'h02);
    add("reti1",        0, 8'h00, 0, 1, 1'b1, 4'd1, 10'h210, 8'h02, 8'h00);
    add("calli1_again", 0, 8'h00, 1, 0, 1'b0, 4'd0, 10'h200, 8'h00, 8'h02);
    add("irq0_c",       0, 8'h01, 0, 0, NEST, 4'd0, 10'h200, 8'h01, 8'h02);
    add("calli0_c",     0, 8'h00, 1, 0, 1'b0, 4'd0, 10'h200,
        NEST ? 8'h00 : 8'h01, NEST ? 8'h03 : 8'h02);
    add("irq4_c",       0, 8'h10, 0, 0, 1'b0, NEST ? 4'd4 : 4'd0,
        NEST ? 10'h240 : 10'h200, NEST ? 8'h10 : 8'h11, NEST ? 8'h03 : 8'h02);
    add("reset_mid",    1, 8'h10, 0, 0, 1'b0, 4'd0, 10'h200, 8'h00, 8'h00);
    add("held_thru_rst",0, 8'h10, 0, 0, 1'b0, 4'd0, 10'h200, 8'h00, 8'h00);
    add("calli_idle",   0, 8'h00, 1, 0, 1'b0, 4'd0, 10'h200, 8'h00, 8'h00);
    add("irq4_rise",    0, 8'h10, 0, 0, 1'b1, 4'd4, 10'h240, 8'h10, 8'h00);

    foreach (vecs[i]) apply(vecs[i]);

    // Every driven record must have been consumed by exactly one comparison.
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
